// File: rtl/cpu_regfile_pkg.sv
// Shared SM83 register-file types: register/pair indices, IDU ops, debug snapshot.
// Pair lookups return 4'hF for an unused pair code so callers can treat it as out of range.
package cpu_regfile_pkg;

    typedef enum logic [3:0] {
        R_A, R_B, R_C, R_D, R_E, R_H, R_L, R_W, R_Z, R_F, R_PCH, R_PCL, R_SPH, R_SPL
    } reg_idx_t;

    typedef enum logic [2:0] {
        P_BC, P_DE, P_HL, P_WZ, P_SP, P_PC, P_AF
    } pair_idx_t;

    typedef enum logic [1:0] {
        IDU_PASS, IDU_INC, IDU_DEC
    } idu_op_t;

    localparam logic [7:0] FLAG_MASK = 8'hF0;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  f;
        logic [7:0]  b;
        logic [7:0]  c;
        logic [7:0]  d;
        logic [7:0]  e;
        logic [7:0]  h;
        logic [7:0]  l;
        logic [7:0]  w;
        logic [7:0]  z;
        logic [15:0] sp;
        logic [15:0] pc;
        logic        ime;
    } cpu_regs_t;

    function automatic logic [3:0] pair_hi(input logic [2:0] p);
        case (p)
            P_BC:    pair_hi = R_B;
            P_DE:    pair_hi = R_D;
            P_HL:    pair_hi = R_H;
            P_WZ:    pair_hi = R_W;
            P_SP:    pair_hi = R_SPH;
            P_PC:    pair_hi = R_PCH;
            P_AF:    pair_hi = R_A;
            default: pair_hi = 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] pair_lo(input logic [2:0] p);
        case (p)
            P_BC:    pair_lo = R_C;
            P_DE:    pair_lo = R_E;
            P_HL:    pair_lo = R_L;
            P_WZ:    pair_lo = R_Z;
            P_SP:    pair_lo = R_SPL;
            P_PC:    pair_lo = R_PCL;
            P_AF:    pair_lo = R_F;
            default: pair_lo = 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/cpu_regfile_idu.sv
// 16-bit increment/decrement/pass unit; purely combinational, wraps at both ends.
module cpu_idu
    import cpu_regfile_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] din,
    input  logic [1:0]   op,
    output logic [W-1:0] dout
);

    always_comb begin
        dout = din;
        case (op)
            IDU_INC: dout = din + W'(1);
            IDU_DEC: dout = din - W'(1);
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/cpu_regfile.sv
// SM83 register file: NUM_RD combinational byte reads, byte/pair/flags writes, IDU and delayed-EI IME.
// Same-edge byte priority is pair write > IDU result > byte write > flags write; F[3:0] always reads 0.
module cpu_regfile
    import cpu_regfile_pkg::*;
#(
    parameter int          DATA_W   = 8,
    parameter int          NUM_REGS = 14,
    parameter int          NUM_RD   = 2,
    parameter int          EI_DELAY = 1,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] RESET_SP = 16'hFFFE
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_RD-1:0][3:0]         rd_sel,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
    input  logic                           wr_en,
    input  logic [3:0]                     wr_sel,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           pair_wr_en,
    input  logic [2:0]                     pair_wr_sel,
    input  logic [2*DATA_W-1:0]            pair_wr_data,
    input  logic                           idu_en,
    input  logic [1:0]                     idu_op,
    input  logic [2:0]                     idu_sel,
    output logic [2*DATA_W-1:0]            idu_addr,
    input  logic                           flags_wr_en,
    input  logic [3:0]                     flags_in,
    output logic [3:0]                     flags_out,
    input  logic                           ime_set,
    input  logic                           ime_clr,
    input  logic                           ime_now,
    input  logic                           instr_bound,
    output logic                           ime,
    output cpu_regs_t                      regs_out
);

    localparam logic [3:0] NREG = 4'(NUM_REGS);
    localparam int         CW   = (EI_DELAY < 1) ? 1 : $clog2(EI_DELAY + 1);

    logic [DATA_W-1:0]   regs     [NUM_REGS];
    logic [DATA_W-1:0]   regs_nxt [NUM_REGS];
    logic [2*DATA_W-1:0] idu_res;
    logic                idu_wr;
    logic [3:0]          idu_hi, idu_lo, pw_hi, pw_lo;

    assign idu_hi = pair_hi(idu_sel);
    assign idu_lo = pair_lo(idu_sel);
    assign pw_hi  = pair_hi(pair_wr_sel);
    assign pw_lo  = pair_lo(pair_wr_sel);

    always_comb begin
        for (int p = 0; p < NUM_RD; p++)
            rd_data[p] = (rd_sel[p] < NREG) ? regs[rd_sel[p]] : '0;
        idu_addr = (idu_hi < NREG) ? {regs[idu_hi], regs[idu_lo]} : '0;
    end

    cpu_idu #(.W(2*DATA_W)) u_idu (
        .din  (idu_addr),
        .op   (idu_op),
        .dout (idu_res)
    );

    assign idu_wr = idu_en && (idu_op == IDU_INC || idu_op == IDU_DEC) && (idu_hi < NREG);

    // Later assignments override earlier ones, giving the per-byte priority order.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_nxt[i] = regs[i];
            if (flags_wr_en && i == int'(R_F))
                regs_nxt[i] = {flags_in, {(DATA_W-4){1'b0}}};
            if (wr_en && wr_sel == 4'(i))
                regs_nxt[i] = wr_data;
            if (idu_wr && idu_hi == 4'(i))
                regs_nxt[i] = idu_res[2*DATA_W-1:DATA_W];
            if (idu_wr && idu_lo == 4'(i))
                regs_nxt[i] = idu_res[DATA_W-1:0];
            if (pair_wr_en && pw_hi == 4'(i))
                regs_nxt[i] = pair_wr_data[2*DATA_W-1:DATA_W];
            if (pair_wr_en && pw_lo == 4'(i))
                regs_nxt[i] = pair_wr_data[DATA_W-1:0];
            if (i == int'(R_F))
                regs_nxt[i] = regs_nxt[i] & FLAG_MASK[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == int'(R_PCH))      regs[i] <= RESET_PC[15:8];
                else if (i == int'(R_PCL)) regs[i] <= RESET_PC[7:0];
                else if (i == int'(R_SPH)) regs[i] <= RESET_SP[15:8];
                else if (i == int'(R_SPL)) regs[i] <= RESET_SP[7:0];
                else                       regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= regs_nxt[i];
        end
    end

    typedef enum logic {IME_IDLE, IME_PENDING} ime_state_t;

    ime_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ime_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IME_IDLE;
            cnt   <= '0;
            ime   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ime   <= ime_nxt;
        end
    end

    // The boundary that coincides with EI belongs to EI itself, so it is not counted.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ime_nxt   = ime;
        if (ime_clr) begin
            state_nxt = IME_IDLE;
            ime_nxt   = 1'b0;
        end else if (ime_now) begin
            state_nxt = IME_IDLE;
            ime_nxt   = 1'b1;
        end else if (ime_set) begin
            state_nxt = IME_PENDING;
            cnt_nxt   = CW'(EI_DELAY);
        end else if (state == IME_PENDING && instr_bound) begin
            if (cnt <= CW'(1)) begin
                state_nxt = IME_IDLE;
                cnt_nxt   = '0;
                ime_nxt   = 1'b1;
            end else begin
                cnt_nxt = cnt - CW'(1);
            end
        end
    end

    assign flags_out = regs[R_F][DATA_W-1:DATA_W-4];

    always_comb begin
        regs_out     = '0;
        regs_out.a   = regs[R_A];
        regs_out.f   = regs[R_F];
        regs_out.b   = regs[R_B];
        regs_out.c   = regs[R_C];
        regs_out.d   = regs[R_D];
        regs_out.e   = regs[R_E];
        regs_out.h   = regs[R_H];
        regs_out.l   = regs[R_L];
        regs_out.w   = regs[R_W];
        regs_out.z   = regs[R_Z];
        regs_out.sp  = {regs[R_SPH], regs[R_SPL]};
        regs_out.pc  = {regs[R_PCH], regs[R_PCL]};
        regs_out.ime = ime;
    end

endmodule

// File: tb/tb_cpu_regfile.sv
// Randomized and directed checks of cpu_regfile against a byte-array/pair-arithmetic reference model.
module tb_cpu_regfile;
    import cpu_regfile_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0][3:0]  rd_sel = '0;
    logic [1:0][7:0]  rd_data;
    logic             wr_en = 1'b0;
    logic [3:0]       wr_sel = '0;
    logic [7:0]       wr_data = '0;
    logic             pair_wr_en = 1'b0;
    logic [2:0]       pair_wr_sel = '0;
    logic [15:0]      pair_wr_data = '0;
    logic             idu_en = 1'b0;
    logic [1:0]       idu_op = '0;
    logic [2:0]       idu_sel = '0;
    logic [15:0]      idu_addr;
    logic             flags_wr_en = 1'b0;
    logic [3:0]       flags_in = '0;
    logic [3:0]       flags_out;
    logic             ime_set = 1'b0, ime_clr = 1'b0, ime_now = 1'b0, instr_bound = 1'b0;
    logic             ime;
    cpu_regs_t        regs_out;

    cpu_regfile dut (
        .clk(clk), .reset(reset), .rd_sel(rd_sel), .rd_data(rd_data),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .pair_wr_en(pair_wr_en), .pair_wr_sel(pair_wr_sel), .pair_wr_data(pair_wr_data),
        .idu_en(idu_en), .idu_op(idu_op), .idu_sel(idu_sel), .idu_addr(idu_addr),
        .flags_wr_en(flags_wr_en), .flags_in(flags_in), .flags_out(flags_out),
        .ime_set(ime_set), .ime_clr(ime_clr), .ime_now(ime_now), .instr_bound(instr_bound),
        .ime(ime), .regs_out(regs_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: 14 bytes in A,B,C,D,E,H,L,W,Z,F,PCH,PCL,SPH,SPL order.
    logic [7:0] m [14];
    logic [7:0] mn [14];
    bit         m_ime, m_pend;
    int         m_cnt;

    function automatic int hi_of(input int p);
        int t [7] = '{1, 3, 5, 7, 12, 10, 0};
        return (p < 7) ? t[p] : -1;
    endfunction

    function automatic int lo_of(input int p);
        int t [7] = '{2, 4, 6, 8, 13, 11, 9};
        return (p < 7) ? t[p] : -1;
    endfunction

    function automatic logic [15:0] get_pair(input int p);
        return (p < 7) ? {m[hi_of(p)], m[lo_of(p)]} : 16'h0;
    endfunction

    task automatic put_pair(input int p, input logic [15:0] v);
        mn[hi_of(p)] = v[15:8];
        mn[lo_of(p)] = v[7:0];
    endtask

    task automatic model_reset();
        foreach (m[i]) m[i] = 8'h00;
        m[12] = 8'hFF; m[13] = 8'hFE;
        m_ime = 0; m_pend = 0; m_cnt = 0;
    endtask

    // Apply lowest-priority writer first so each higher one overwrites it.
    task automatic model_clock();
        logic [15:0] old_idu;
        old_idu = get_pair(int'(idu_sel));
        foreach (m[i]) mn[i] = m[i];
        if (flags_wr_en) mn[9] = {flags_in, 4'h0};
        if (wr_en && wr_sel < 14) mn[wr_sel] = wr_data;
        if (idu_en && idu_sel < 7 && idu_op == 2'd1) put_pair(int'(idu_sel), old_idu + 16'd1);
        if (idu_en && idu_sel < 7 && idu_op == 2'd2) put_pair(int'(idu_sel), old_idu - 16'd1);
        if (pair_wr_en && pair_wr_sel < 7) put_pair(int'(pair_wr_sel), pair_wr_data);
        mn[9] = mn[9] & 8'hF0;
        foreach (m[i]) m[i] = mn[i];
        if (ime_clr) begin
            m_ime = 0; m_pend = 0;
        end else if (ime_now) begin
            m_ime = 1; m_pend = 0;
        end else if (ime_set) begin
            m_pend = 1; m_cnt = 1;
        end else if (m_pend && instr_bound) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_ime = 1; m_pend = 0;
            end
        end
    endtask

    task automatic check_model();
        for (int p = 0; p < 2; p++)
            chk($sformatf("rd_data%0d", p), rd_data[p], (rd_sel[p] < 14) ? m[rd_sel[p]] : 8'h00);
        chk("idu_addr", idu_addr, get_pair(int'(idu_sel)));
        chk("flags_out", flags_out, m[9][7:4]);
        chk("ime", ime, m_ime);
        chk("regs_out.pc", regs_out.pc, {m[10], m[11]});
        chk("regs_out.sp", regs_out.sp, {m[12], m[13]});
        chk("regs_out.hl", {regs_out.h, regs_out.l}, {m[5], m[6]});
    endtask

    task automatic clear_strobes();
        wr_en = 0; pair_wr_en = 0; idu_en = 0; flags_wr_en = 0;
        ime_set = 0; ime_clr = 0; ime_now = 0; instr_bound = 0;
    endtask

    task automatic step();
        #1 check_model();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        clear_strobes();
    endtask

    initial begin
        model_reset();
        #12 @(negedge clk);
        reset = 0;
        #1;
        chk("rst_pc", regs_out.pc, 16'h0000);
        chk("rst_sp", regs_out.sp, 16'hFFFE);
        chk("rst_a", regs_out.a, 8'h00);
        chk("rst_z", regs_out.z, 8'h00);
        chk("rst_ime", ime, 1'b0);

        pair_wr_en = 1; pair_wr_sel = 3'd6; pair_wr_data = 16'h12FF;
        step();
        rd_sel[0] = 4'd0; rd_sel[1] = 4'd9;
        #1;
        chk("af_a", rd_data[0], 8'h12);
        chk("af_f", rd_data[1], 8'hF0);
        chk("af_flags", flags_out, 4'hF);

        pair_wr_en = 1; pair_wr_sel = 3'd4; pair_wr_data = 16'hFFFF;
        step();
        idu_en = 1; idu_op = 2'd1; idu_sel = 3'd4;
        #1 chk("sp_addr", idu_addr, 16'hFFFF);
        step();
        #1 chk("sp_wrap", regs_out.sp, 16'h0000);

        pair_wr_en = 1; pair_wr_sel = 3'd0; pair_wr_data = 16'h0000;
        step();
        idu_en = 1; idu_op = 2'd2; idu_sel = 3'd0;
        step();
        rd_sel[0] = 4'd1; rd_sel[1] = 4'd2;
        #1 chk("bc_dec", {rd_data[0], rd_data[1]}, 16'hFFFF);

        pair_wr_en = 1; pair_wr_sel = 3'd2; pair_wr_data = 16'hBEEF;
        wr_en = 1; wr_sel = 4'd6; wr_data = 8'h11;
        idu_en = 1; idu_op = 2'd1; idu_sel = 3'd2;
        step();
        #1 chk("hl_prio", {regs_out.h, regs_out.l}, 16'hBEEF);

        ime_set = 1; instr_bound = 1;
        step();
        #1 chk("ei_wait0", ime, 1'b0);
        step();
        #1 chk("ei_wait1", ime, 1'b0);
        instr_bound = 1;
        step();
        #1 chk("ei_on", ime, 1'b1);

        ime_set = 1; ime_clr = 1;
        step();
        #1 chk("set_clr", ime, 1'b0);
        instr_bound = 1;
        step();
        step();
        #1 chk("no_pend", ime, 1'b0);

        ime_set = 1;
        step();
        ime_now = 1;
        step();
        #1 chk("now_on", ime, 1'b1);
        instr_bound = 1;
        step();
        #1 chk("now_bound", ime, 1'b1);
        ime_clr = 1;
        step();
        #1 chk("now_clr", ime, 1'b0);

        ime_set = 1;
        step();
        #2 reset = 1;
        #1;
        chk("arst_pc", regs_out.pc, 16'h0000);
        chk("arst_sp", regs_out.sp, 16'hFFFE);
        chk("arst_hl", {regs_out.h, regs_out.l}, 16'h0000);
        @(negedge clk);
        reset = 0;
        model_reset();
        instr_bound = 1;
        step();
        instr_bound = 1;
        step();
        #1 chk("arst_ime", ime, 1'b0);

        for (int cyc = 0; cyc < 600; cyc++) begin
            rd_sel[0]    = 4'($urandom_range(0, 15));
            rd_sel[1]    = 4'($urandom_range(0, 15));
            wr_en        = ($urandom_range(0, 2) == 0);
            wr_sel       = 4'($urandom_range(0, 15));
            wr_data      = 8'($urandom);
            pair_wr_en   = ($urandom_range(0, 3) == 0);
            pair_wr_sel  = 3'($urandom_range(0, 7));
            pair_wr_data = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
            idu_en       = ($urandom_range(0, 1) == 0);
            idu_op       = 2'($urandom_range(0, 3));
            idu_sel      = 3'($urandom_range(0, 7));
            flags_wr_en  = ($urandom_range(0, 2) == 0);
            flags_in     = 4'($urandom);
            ime_set      = ($urandom_range(0, 5) == 0);
            ime_clr      = ($urandom_range(0, 9) == 0);
            ime_now      = ($urandom_range(0, 11) == 0);
            instr_bound  = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
